// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared frame-buffer constants, bank type, swap FSM encoding
//               and the address-width helper used by the arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int c_FB_WIDTH   = 320;
    localparam int c_FB_HEIGHT  = 180;
    localparam int c_SCALE_LOG2 = 2;

    // Two banks of FB_WIDTH x FB_HEIGHT pixels share one linear address space.
    function automatic int fb_addr_w(input int width, input int height);
        return $clog2(2 * width * height);
    endfunction

    localparam int c_ADDR_W = fb_addr_w(c_FB_WIDTH, c_FB_HEIGHT);

    typedef logic bank_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_addr_calc.sv
`default_nettype none
// ============================================================================
// Module      : fb_addr_calc
// Description : Combinational bank/x/y to linear frame-buffer address.
//               addr = bank*W*H + y*W + x
// Revision    : 1.0 - initial release
// ============================================================================
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = c_FB_WIDTH,
    parameter int FB_HEIGHT = c_FB_HEIGHT,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int ADDR_W    = fb_addr_w(FB_WIDTH, FB_HEIGHT)
) (
    input  bank_t             bank_in,
    input  logic [X_W-1:0]    x_in,
    input  logic [Y_W-1:0]    y_in,
    output logic [ADDR_W-1:0] addr_out
);

    localparam logic [ADDR_W-1:0] c_BANK_SIZE  = ADDR_W'(FB_WIDTH * FB_HEIGHT);
    localparam logic [ADDR_W-1:0] c_ROW_STRIDE = ADDR_W'(FB_WIDTH);

    // Linear address: bank base plus row offset plus column.
    always_comb begin
        addr_out = (bank_in ? c_BANK_SIZE : '0)
                 + ADDR_W'(y_in) * c_ROW_STRIDE
                 + ADDR_W'(x_in);
    end

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter
// Description : Shares the single frame-buffer port between display scan-out
//               (fixed read slots, always win) and renderer writes (valid/
//               ready), and flips front/back bank only at frame boundaries.
//               Optional FB_ARBITER_STATS_EN adds drop/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int FB_WIDTH   = c_FB_WIDTH,
    parameter int FB_HEIGHT  = c_FB_HEIGHT,
    parameter int SCALE_LOG2 = c_SCALE_LOG2,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int H_W        = 11,
    parameter int V_W        = 10,
    localparam int ADDR_W    = fb_addr_w(FB_WIDTH, FB_HEIGHT)
) (
    input  logic              clk_pixel_in,
    input  logic              rst_n_in,
    input  logic [H_W-1:0]    hcount_in,
    input  logic [V_W-1:0]    vcount_in,
    input  logic              ad_in,
    input  logic              nf_in,
    input  logic              wr_valid_in,
    output logic              wr_ready_out,
    input  logic [8:0]        wr_x_in,
    input  logic [7:0]        wr_y_in,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic              swap_req_in,
    output logic              swap_ack_out,
    output logic              front_bank_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_we_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic [DATA_W-1:0] mem_rdata_in,
    output logic [DATA_W-1:0] pixel_out
`ifdef FB_ARBITER_STATS_EN
    ,
    output logic [15:0]       wr_drop_count_out,
    output logic [15:0]       wr_stall_count_out
`endif
);

    localparam logic [0:0]     c_ST_IDLE    = IDLE;
    localparam logic [0:0]     c_ST_PENDING = PENDING;
    localparam logic [H_W-1:0] c_SUB_MASK   = H_W'((1 << SCALE_LOG2) - 1);

    logic              w_read_slot;
    logic              w_wr_accept;
    logic              w_wr_in_range;
    logic              w_nf_rise;
    logic [H_W-1:0]    w_rd_x;
    logic [V_W-1:0]    w_rd_y;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;

    bank_t             r_bank;
    logic [0:0]        r_state;
    logic              r_nf_q;
    logic              r_ack;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [MEM_LAT-1:0] r_slot_dly;
    logic [MEM_LAT-1:0] r_ad_dly;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_pixel;

    // Scan-out owns the first pixel of every upscaled FB column.
    assign w_read_slot   = ad_in && ((hcount_in & c_SUB_MASK) == '0);
    assign wr_ready_out  = rst_n_in && !w_read_slot;
    assign w_wr_accept   = wr_valid_in && wr_ready_out;
    assign w_wr_in_range = (32'(wr_x_in) < 32'(FB_WIDTH)) && (32'(wr_y_in) < 32'(FB_HEIGHT));
    assign w_nf_rise     = nf_in && !r_nf_q;

    assign w_rd_x = hcount_in >> SCALE_LOG2;
    assign w_rd_y = vcount_in >> SCALE_LOG2;

    fb_addr_calc #(
        .FB_WIDTH (FB_WIDTH),
        .FB_HEIGHT(FB_HEIGHT),
        .X_W      (H_W),
        .Y_W      (V_W),
        .ADDR_W   (ADDR_W)
    ) u_rd_addr (
        .bank_in (r_bank),
        .x_in    (w_rd_x),
        .y_in    (w_rd_y),
        .addr_out(w_rd_addr)
    );

    // Writes always go to the back bank, i.e. the one not on screen.
    fb_addr_calc #(
        .FB_WIDTH (FB_WIDTH),
        .FB_HEIGHT(FB_HEIGHT),
        .X_W      (9),
        .Y_W      (8),
        .ADDR_W   (ADDR_W)
    ) u_wr_addr (
        .bank_in (~r_bank),
        .x_in    (wr_x_in),
        .y_in    (wr_y_in),
        .addr_out(w_wr_addr)
    );

    // Memory request register: read slot first, then an in-range write, else idle.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else if (w_read_slot) begin
            r_mem_addr  <= w_rd_addr;
            r_mem_we    <= 1'b0;
        end else if (w_wr_accept && w_wr_in_range) begin
            r_mem_addr  <= w_wr_addr;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= wr_data_in;
        end else begin
            r_mem_we    <= 1'b0;
        end
    end

    // Delay slot and active flags to line up with returning read data.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_slot_dly <= '0;
            r_ad_dly   <= '0;
        end else begin
            r_slot_dly[0] <= w_read_slot;
            r_ad_dly[0]   <= ad_in;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_slot_dly[i] <= r_slot_dly[i-1];
                r_ad_dly[i]   <= r_ad_dly[i-1];
            end
        end
    end

    // Capture read data and hold it across the upscaled pixel; blank outside active.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_data <= '0;
            r_pixel   <= '0;
        end else begin
            if (r_slot_dly[MEM_LAT-1]) begin
                r_rd_data <= mem_rdata_in;
            end
            if (!r_ad_dly[MEM_LAT-1]) begin
                r_pixel <= '0;
            end else if (r_slot_dly[MEM_LAT-1]) begin
                r_pixel <= mem_rdata_in;
            end else begin
                r_pixel <= r_rd_data;
            end
        end
    end

    // Swap FSM: arm on request, acknowledge on the next frame edge, flip bank a cycle later.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= c_ST_IDLE;
            r_nf_q  <= 1'b0;
            r_ack   <= 1'b0;
            r_bank  <= 1'b0;
        end else begin
            r_nf_q <= nf_in;
            r_ack  <= 1'b0;
            if (r_ack) begin
                r_bank <= ~r_bank;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (swap_req_in) begin
                        if (w_nf_rise) begin
                            r_ack <= 1'b1;
                        end else begin
                            r_state <= c_ST_PENDING;
                        end
                    end
                end
                c_ST_PENDING: begin
                    if (w_nf_rise) begin
                        r_ack   <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign mem_addr_out   = r_mem_addr;
    assign mem_we_out     = r_mem_we;
    assign mem_wdata_out  = r_mem_wdata;
    assign pixel_out      = r_pixel;
    assign swap_ack_out   = r_ack;
    assign front_bank_out = r_bank;

`ifdef FB_ARBITER_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_stall_cnt;

    // Saturating counters for dropped out-of-range writes and stalled write cycles.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_drop_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_wr_accept && !w_wr_in_range && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (wr_valid_in && !wr_ready_out && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign wr_drop_count_out  = r_drop_cnt;
    assign wr_stall_count_out = r_stall_cnt;
`endif

endmodule
`default_nettype wire
